// File: rtl/sw_conditioner.sv
// Board switch conditioner: two-flop synchronizer, optional tick-based debounce, and
// registered per-bit edge pulses. Debounce is built only with SW_CONDITIONER_DEBOUNCE_EN.
module sw_conditioner #(
    parameter int unsigned Width   = 32,
    parameter int unsigned TickDiv = 1000,
    parameter int unsigned Stable  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] sw_i,
    output logic [Width-1:0] io_sw,
    output logic [Width-1:0] sw_rise,
    output logic [Width-1:0] sw_fall,
    output logic             sw_changed
);

    if (TickDiv < 2 || TickDiv > 65535) begin : g_bad_tickdiv
        $error("sw_conditioner: TickDiv out of range 2..65535");
    end
    if (Stable < 2 || Stable > 15) begin : g_bad_stable
        $error("sw_conditioner: Stable out of range 2..15");
    end

    logic [Width-1:0] sync1_q;
    logic [Width-1:0] io_q;
    logic [Width-1:0] io_d;
    logic [Width-1:0] rise_q;
    logic [Width-1:0] fall_q;
    logic             changed_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
        end else begin
            sync1_q <= sw_i;
        end
    end

`ifdef SW_CONDITIONER_DEBOUNCE_EN
    localparam logic [15:0] TickLast   = 16'(TickDiv - 1);
    localparam logic [3:0]  StableLast = 4'(Stable - 1);

    logic [Width-1:0]      sync2_q;
    logic [15:0]           pre_q;
    logic [15:0]           pre_d;
    logic                  tick;
    logic [Width-1:0][3:0] cnt_q;
    logic [Width-1:0][3:0] cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync2_q <= '0;
            pre_q   <= '0;
            cnt_q   <= '0;
        end else begin
            sync2_q <= sync1_q;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        tick  = (pre_q == TickLast);
        pre_d = tick ? 16'd0 : pre_q + 16'd1;
    end

    // A bit flips only after Stable consecutive ticks disagreeing with io_sw;
    // any agreeing tick restarts the run.
    always_comb begin
        io_d  = io_q;
        cnt_d = cnt_q;
        if (tick) begin
            for (int unsigned b = 0; b < Width; b++) begin
                if (sync2_q[b] == io_q[b]) begin
                    cnt_d[b] = 4'd0;
                end else if (cnt_q[b] == StableLast) begin
                    io_d[b]  = sync2_q[b];
                    cnt_d[b] = 4'd0;
                end else begin
                    cnt_d[b] = cnt_q[b] + 4'd1;
                end
            end
        end
    end
`else
    // io_q doubles as the second synchronizer flop.
    always_comb begin
        io_d = sync1_q;
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            io_q      <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            io_q      <= io_d;
            rise_q    <= io_d & ~io_q;
            fall_q    <= ~io_d & io_q;
            changed_q <= |(io_d ^ io_q);
        end
    end

    always_comb begin
        io_sw      = io_q;
        sw_rise    = rise_q;
        sw_fall    = fall_q;
        sw_changed = changed_q;
    end

endmodule

// File: tb/tb_sw_conditioner.sv
// Bench for sw_conditioner: directed scenarios plus random switch activity, checked every
// cycle against a run-length reference model. Honours SW_CONDITIONER_DEBOUNCE_EN.
module tb_sw_conditioner;

    localparam int WIDTH   = 32;
    localparam int TICKDIV = 4;
    localparam int STABLE  = 3;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] io_sw;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;

    sw_conditioner #(
        .Width  (WIDTH),
        .TickDiv(TICKDIV),
        .Stable (STABLE)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .sw_i      (sw),
        .io_sw     (io_sw),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_changed(sw_changed)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference state: two-cycle input delay, edges since release, disagreeing-tick runs.
    logic [WIDTH-1:0] m_s1, m_s2, m_io, m_rise, m_fall;
    logic             m_chg;
    int               m_k;
    int               m_run [WIDTH];

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        chk("io_sw", io_sw, m_io);
        chk("sw_rise", sw_rise, m_rise);
        chk("sw_fall", sw_fall, m_fall);
        chk("sw_changed", {31'd0, sw_changed}, {31'd0, m_chg});
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_io = '0;
        m_rise = '0; m_fall = '0; m_chg = 1'b0;
        m_k = 0;
        for (int b = 0; b < WIDTH; b++) m_run[b] = 0;
    endtask

    // Advance the model by one clock edge using the currently applied sw.
    task automatic model_step();
        logic [WIDTH-1:0] nio;
        nio = m_io;
`ifdef SW_CONDITIONER_DEBOUNCE_EN
        if ((m_k % TICKDIV) == TICKDIV - 1) begin
            for (int b = 0; b < WIDTH; b++) begin
                if (m_s2[b] != m_io[b]) begin
                    m_run[b]++;
                    if (m_run[b] == STABLE) begin
                        nio[b] = m_s2[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
        end
`else
        nio = m_s1;
`endif
        m_rise = nio & ~m_io;
        m_fall = m_io & ~nio;
        m_chg  = |(nio ^ m_io);
        m_io   = nio;
        m_s2   = m_s1;
        m_s1   = sw;
        m_k++;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input int n, input logic [WIDTH-1:0] sw_rel);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        repeat (n) begin
            @(posedge clk);
            #1;
            check_outputs();
        end
        sw  = sw_rel;
        rst = 1'b0;
    endtask

    initial begin
        int lat;
        int pulses;
        logic seen;
        logic [WIDTH-1:0] mask;

        clk = 1'b0;
        rst = 1'b0;
        sw  = '1;
        model_reset();

        // Reset with all switches high: everything stays at zero.
        do_reset(4, '0);
        repeat (4) cycle();

        // Single clean rising edge on bit 0.
        sw[0] = 1'b1;
        lat = -1;
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (io_sw[0] && lat < 0) lat = i;
            if (sw_rise != '0) pulses++;
            if (sw_fall != '0) pulses += 100;
        end
        chk("bit0_latency_in_bound", {31'd0, (lat >= 1 && lat <= 15)}, 32'd1);
        chk("bit0_single_rise", pulses, 1);

        // Short pulse on bit 5 (two ticks) must be rejected.
        sw[5] = 1'b1;
        pulses = 0;
        repeat (8) begin
            cycle();
            if (sw_changed) pulses++;
        end
        sw[5] = 1'b0;
        repeat (12) begin
            cycle();
            if (sw_changed) pulses++;
        end
`ifdef SW_CONDITIONER_DEBOUNCE_EN
        chk("bit5_glitch_io", {31'd0, io_sw[5]}, 32'd0);
        chk("bit5_glitch_pulses", pulses, 0);
`endif

        // Byte swap: every affected bit updates and pulses in the same cycle.
        sw = 32'h0000_00FF;
        repeat (20) cycle();
        sw = 32'hFF00_0000;
        seen = 1'b0;
        repeat (20) begin
            cycle();
            if (io_sw == 32'hFF00_0000 && sw_rise == 32'hFF00_0000 &&
                sw_fall == 32'h0000_00FF && sw_changed) seen = 1'b1;
        end
        chk("byte_swap_coincident", {31'd0, seen}, 32'd1);

        // Reset mid-count on bit 3 discards the partial run.
        sw = 32'hFF00_0008;
        for (int i = 0; i < 20 && m_run[3] != 2; i++) cycle();
        do_reset(2, 32'h0000_0008);
        lat = -1;
        for (int i = 1; i <= 24; i++) begin
            cycle();
            if (io_sw[3] && lat < 0) lat = i;
        end
`ifdef SW_CONDITIONER_DEBOUNCE_EN
        chk("bit3_after_reset_latency", lat, TICKDIV * STABLE);
`else
        chk("bit3_after_reset_latency", lat, 2);
`endif

        // Random activity: sparse toggles, occasional glitches and resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                mask = $urandom() & $urandom() & $urandom();
                sw = sw ^ mask;
            end
            if ($urandom_range(0, 199) == 0) begin
                do_reset($urandom_range(1, 2), sw);
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
